drum_arbiter: RTL and testbench
===============================

DRUM_ARBITER -- requirements
Module: drum_arbiter

Interface
REQ-001 The block SHALL have parameter K, default 6, which is the drum segment width passed to the internal drum instance.
REQ-002 The block SHALL have parameter N, default 8, which is the operand width of both a and b.
REQ-003 The block SHALL have parameter ACC_W, default 24, which is the per-requester accumulator width (ACC_W >= 2*N).
REQ-004 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  Reset; synchronous, active-high.
REQ-006 reqX_valid  input  1  (X = 0,1) Requester X presents an operation.
REQ-007 reqX_ready  output  1  Requester X's operation is accepted this cycle.
REQ-008 reqX_a, reqX_b  input  N each  Signed two's-complement operands.
REQ-009 reqX_acc  input  1  1 = accumulate into the accumulator; 0 = load the accumulator with the product.
REQ-010 respX_valid  output  1  The result for requester X is available.
REQ-011 respX_ready  input  1  Requester X consumes the result.
REQ-012 respX_data  output  ACC_W  Accumulator value of requester X after the operation.

Function
REQ-013 The block SHALL contain exactly one drum multiplier instance (k=K, n=N, m=N), shared by both requesters.
REQ-014 The FSM SHALL have three states: IDLE, MUL and RESP; the reset state SHALL be IDLE.
REQ-015 IDLE behaviour: if any reqX_valid is high, the block SHALL select a winner, drive ready high for the winner only in that cycle, latch a, b, acc and the winner id, and go to MUL; otherwise it SHALL stay in IDLE.
REQ-016 Each reqX_ready SHALL be combinational: (state==IDLE) & grant[X]. It SHALL never be high outside IDLE, and never high for both requesters at once.
REQ-017 Arbitration SHALL be round-robin using a 1-bit priority pointer. The pointer SHALL reset to 0 (requester 0 preferred), and after a grant to i the pointer SHALL become 1-i.
REQ-018 If only one requester is valid, it SHALL win regardless of the pointer.
REQ-019 MUL behaviour: the block SHALL capture the drum output r (2N bits) and sign-extend it to ACC_W.
  - If acc=1, accX SHALL become accX + product, modulo 2^ACC_W (wraps, no saturation).
  - If acc=0, accX SHALL become the product.
  - The FSM SHALL then go to RESP.
REQ-020 The product SHALL equal the drum output bit-exactly; the block SHALL NOT correct the approximation or the sign.
REQ-021 RESP behaviour: respX_valid SHALL be high for the latched id only, with respX_data = accX. On respX_ready=1 the FSM SHALL go to IDLE; otherwise it SHALL hold, and the data SHALL stay stable.
REQ-022 Latency: acceptance in cycle T SHALL give respX_valid from cycle T+2. Minimum issue interval is 3 cycles.
REQ-023 If respX_ready is already high on entering RESP, the response SHALL last exactly one cycle.
REQ-024 The non-selected requester SHALL keep its request pending. The block SHALL NOT require the requester to hold its operands after acceptance.
REQ-025 The accumulator of the requester not being served SHALL be unchanged.
REQ-026 respX_data SHALL be driven from the accumulator registers at all times; only respX_valid qualifies it.

Reset
REQ-027 While rst=1 at a clock edge, the following SHALL hold at the next cycle:
  - state=IDLE;
  - pointer=0;
  - acc0=acc1=0;
  - all ready and valid outputs 0;
  - respX_data=0.
REQ-028 Reset during MUL or RESP SHALL abort the transaction, with no response issued.
REQ-029 The first grant after reset release SHALL be possible in the first cycle with rst=0.

Verification
REQ-030 Single op: req0 a=3, b=5, acc=0, accepted at T -> resp0_valid at T+2 with resp0_data=15; req1 outputs stay 0.
REQ-031 Accumulate: req1 a=3, b=5, acc=0 -> 15; then req1 a=10, b=12, acc=1 -> resp1_data=135; acc0 stays 0.
REQ-032 Contention: both valid continuously from reset -> grants alternate 0,1,0,1; ready is never high for both; each grant is 3 cycles apart when resp_ready=1.
REQ-033 Negative/approximate: req0 a=-3 (0xFD), b=5, acc=0 -> resp0_data=0xFFFFF5 (-11, drum ones-complement result).
REQ-034 Backpressure and reset: resp0_ready=0 for 5 cycles -> resp0_valid and data are held and no new ready is issued; assert rst during RESP -> next cycle all outputs 0 and acc0=0.

Source files
------------

// File: rtl/drum_arbiter_if.sv
// drum_arbiter_if
//   Handshake bundle between two requesters and the shared DRUM
//   multiply-accumulate arbiter.
//   req0_*/req1_*  : operation request (valid/ready, signed operands a/b,
//                    acc = accumulate (1) or load (0))
//   resp0_*/resp1_*: result channel (valid/ready, ACC_W-bit accumulator value)
//   slave  modport : arbiter side
//   master modport : requester side
interface drum_arbiter_if #(
  parameter int N     = 8,
  parameter int ACC_W = 24
);
  logic                req0_valid;
  logic                req0_ready;
  logic signed [N-1:0] req0_a;
  logic signed [N-1:0] req0_b;
  logic                req0_acc;
  logic                resp0_valid;
  logic                resp0_ready;
  logic [ACC_W-1:0]    resp0_data;

  logic                req1_valid;
  logic                req1_ready;
  logic signed [N-1:0] req1_a;
  logic signed [N-1:0] req1_b;
  logic                req1_acc;
  logic                resp1_valid;
  logic                resp1_ready;
  logic [ACC_W-1:0]    resp1_data;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_acc, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_acc, resp1_ready,
    output req0_ready, resp0_valid, resp0_data,
    output req1_ready, resp1_valid, resp1_data
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_acc, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_acc, resp1_ready,
    input  req0_ready, resp0_valid, resp0_data,
    input  req1_ready, resp1_valid, resp1_data
  );
endinterface

// File: rtl/drum_arbiter.sv
// drum_arbiter
//   Two requesters share one DRUM approximate multiplier. Each requester owns
//   an ACC_W-bit accumulator that is either loaded with the product or has the
//   product added to it (wrapping). Arbitration is round-robin with a 1-bit
//   priority pointer. One operation is in flight at a time:
//   IDLE (grant) -> MUL (update accumulator) -> RESP (hold result until taken).
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : drum_arbiter_if.slave (request and response channels)
//
// drum
//   Combinational DRUM multiplier. Operands are turned into magnitudes with a
//   ones-complement, each magnitude is reduced to a k-bit segment starting at
//   its leading one (segment LSB forced to 1 to unbias the truncation), the
//   segments are multiplied and shifted back, and the sign is re-applied with
//   a ones-complement.
//   Ports:
//     a_i : signed n-bit operand
//     b_i : signed m-bit operand
//     r_o : signed (n+m)-bit approximate product
module drum_arbiter #(
  parameter int K     = 6,
  parameter int N     = 8,
  parameter int ACC_W = 24
) (
  input logic           clk,
  input logic           rst,
  drum_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     ptr_q, ptr_d;
  logic                     id_q, id_d;
  logic                     mode_q, mode_d;
  logic signed [N-1:0]      a_q, a_d;
  logic signed [N-1:0]      b_q, b_d;
  logic signed [ACC_W-1:0]  acc0_q, acc0_d;
  logic signed [ACC_W-1:0]  acc1_q, acc1_d;
  logic [1:0]               grant;
  logic signed [2*N-1:0]    prod_r;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sel;
  logic signed [ACC_W-1:0]  acc_new;

  drum #(.k(K), .n(N), .m(N)) u_drum (
    .a_i (a_q),
    .b_i (b_q),
    .r_o (prod_r)
  );

  // Signed size cast sign-extends the raw drum result; no correction applied.
  assign prod_ext = ACC_W'(prod_r);
  assign acc_sel  = id_q ? acc1_q : acc0_q;
  assign acc_new  = mode_q ? (acc_sel + prod_ext) : prod_ext;

  // Pointer only matters when both requesters compete.
  always_comb begin
    grant = 2'b00;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant = {bus.req1_valid, bus.req0_valid};
    end
  end

  // Ready is masked by rst so nothing is accepted while reset is asserted.
  assign bus.req0_ready  = (state_q == IDLE) & grant[0] & ~rst;
  assign bus.req1_ready  = (state_q == IDLE) & grant[1] & ~rst;
  assign bus.resp0_valid = (state_q == RESP) & ~id_q;
  assign bus.resp1_valid = (state_q == RESP) & id_q;
  assign bus.resp0_data  = acc0_q;
  assign bus.resp1_data  = acc1_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = MUL;
          // Winner i hands priority to 1-i: grant[0] set means pointer -> 1.
          ptr_d   = grant[0];
          id_d    = grant[1];
          a_d     = grant[1] ? bus.req1_a   : bus.req0_a;
          b_d     = grant[1] ? bus.req1_b   : bus.req0_b;
          mode_d  = grant[1] ? bus.req1_acc : bus.req0_acc;
        end
      end
      MUL: begin
        state_d = RESP;
        if (id_q) begin
          acc1_d = acc_new;
        end else begin
          acc0_d = acc_new;
        end
      end
      RESP: begin
        if (id_q ? bus.resp1_ready : bus.resp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      acc0_q  <= '0;
      acc1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
    end
  end

  // Operand latches are only consumed in MUL after a grant; no reset needed.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    mode_q <= mode_d;
  end

endmodule

module drum #(
  parameter int k = 6,
  parameter int n = 8,
  parameter int m = 8
) (
  input  logic signed [n-1:0]   a_i,
  input  logic signed [m-1:0]   b_i,
  output logic signed [n+m-1:0] r_o
);

  logic           sign_p;
  logic [n-1:0]   mag_a;
  logic [m-1:0]   mag_b;
  logic [k-1:0]   seg_a;
  logic [k-1:0]   seg_b;
  int             lead_a, lead_b;
  int             sh_a, sh_b;
  logic [2*k-1:0] prod_seg;
  logic [n+m-1:0] prod_mag;

  assign sign_p = a_i[n-1] ^ b_i[m-1];
  assign mag_a  = a_i ^ {n{a_i[n-1]}};
  assign mag_b  = b_i ^ {m{b_i[m-1]}};

  always_comb begin
    lead_a = 0;
    sh_a   = 0;
    seg_a  = '0;
    for (int i = 0; i < n; i++) begin
      if (mag_a[i]) lead_a = i;
    end
    if (lead_a >= k) begin
      sh_a     = lead_a - k + 1;
      seg_a    = k'(mag_a >> sh_a);
      seg_a[0] = 1'b1;
    end else begin
      seg_a = mag_a[k-1:0];
    end
  end

  always_comb begin
    lead_b = 0;
    sh_b   = 0;
    seg_b  = '0;
    for (int i = 0; i < m; i++) begin
      if (mag_b[i]) lead_b = i;
    end
    if (lead_b >= k) begin
      sh_b     = lead_b - k + 1;
      seg_b    = k'(mag_b >> sh_b);
      seg_b[0] = 1'b1;
    end else begin
      seg_b = mag_b[k-1:0];
    end
  end

  assign prod_seg = {{k{1'b0}}, seg_a} * {{k{1'b0}}, seg_b};
  assign prod_mag = (n+m)'(prod_seg) << (sh_a + sh_b);
  assign r_o      = prod_mag ^ {(n+m){sign_p}};

endmodule

// File: tb/tb_drum_arbiter.sv
// Scoreboard bench for drum_arbiter: drivers push the expected accumulator
// value on acceptance, a negedge monitor compares whenever a response is shown.
module tb_drum_arbiter;
  localparam int K     = 6;
  localparam int N     = 8;
  localparam int ACC_W = 24;

  typedef struct {
    logic [ACC_W-1:0] d;
    int               t;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   rr_mode;
  bit   cont_mode;
  bit   first_grant;
  int   rel_cyc;
  int   last_gid;
  int   last_cyc;
  int   n_grants;
  bit   seen0, seen1;
  exp_t q0[$];
  exp_t q1[$];
  logic [ACC_W-1:0] acc_m [2];

  drum_arbiter_if #(.N(N), .ACC_W(ACC_W)) bus ();

  drum_arbiter #(.K(K), .N(N), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference DRUM: reduce a magnitude to K significant bits below its
  // leading one, rounding the kept LSB up to 1.
  function automatic longint approx(input longint x);
    longint p, s;
    if (x < (longint'(1) << K)) return x;
    p = 0;
    while ((x >> (p + 1)) != 0) p++;
    s = p - K + 1;
    return ((x >> s) | 1) << s;
  endfunction

  function automatic longint drum_ref(input int a, input int b);
    longint ma, mb, pr;
    ma = (a < 0) ? -longint'(a) - 1 : longint'(a);
    mb = (b < 0) ? -longint'(b) - 1 : longint'(b);
    pr = approx(ma) * approx(mb);
    return ((a < 0) != (b < 0)) ? -pr - 1 : pr;
  endfunction

  function automatic int rnd_op();
    case ($urandom_range(0, 7))
      0: return -128;
      1: return 127;
      2: return -1;
      3: return 0;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int x, input bit v, input int a, input int b, input bit ac);
    if (x == 0) begin
      bus.req0_valid = v; bus.req0_a = N'(a); bus.req0_b = N'(b); bus.req0_acc = ac;
    end else begin
      bus.req1_valid = v; bus.req1_a = N'(a); bus.req1_b = N'(b); bus.req1_acc = ac;
    end
  endtask

  task automatic issue(input int x, input int a, input int b, input bit ac);
    bit     got;
    int     t;
    longint res;
    exp_t   e;
    drive(x, 1'b1, a, b, ac);
    got = 1'b0;
    t   = 0;
    while (!got && t < 60) begin
      @(negedge clk);
      if (((x == 0) ? bus.req0_ready : bus.req1_ready) === 1'b1) begin
        got = 1'b1;
        res = drum_ref(a, b);
        acc_m[x] = ac ? (acc_m[x] + ACC_W'(res)) : ACC_W'(res);
        e.d = acc_m[x];
        e.t = cyc;
        if (x == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      t++;
      @(posedge clk);
      #1;
    end
    chk($sformatf("accept_req%0d", x), 64'(got), 64'(1));
    // Operands are scrambled after acceptance; the DUT must have latched them.
    drive(x, 1'b0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
  endtask

  task automatic flush();
    q0.delete();
    q1.delete();
    acc_m[0] = '0;
    acc_m[1] = '0;
    seen0 = 1'b0;
    seen1 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready0"}, 64'(bus.req0_ready), 64'(0));
    chk({tag, "_ready1"}, 64'(bus.req1_ready), 64'(0));
    chk({tag, "_valid0"}, 64'(bus.resp0_valid), 64'(0));
    chk({tag, "_valid1"}, 64'(bus.resp1_valid), 64'(0));
    chk({tag, "_data0"},  64'(bus.resp0_data), 64'(0));
    chk({tag, "_data1"},  64'(bus.resp1_data), 64'(0));
  endtask

  task automatic apply_reset(input bit expect_grant);
    rst = 1'b1;
    step(2);
    flush();
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;
    first_grant = expect_grant;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
      step(1);
      t++;
    end
    chk("drain_pending", 64'(q0.size() + q1.size()), 64'(0));
    step(2);
  endtask

  // Response-ready generator: 0 = always ready, 1 = random, 2 = req0 stalled.
  initial begin
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: begin bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1; end
        1: begin
          bus.resp0_ready = ($urandom_range(0, 3) != 0);
          bus.resp1_ready = ($urandom_range(0, 3) != 0);
        end
        default: begin bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b1; end
      endcase
    end
  end

  // Monitor
  initial begin
    logic r0, r1, v0, v1;
    forever begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      v0 = bus.resp0_valid; v1 = bus.resp1_valid;
      if (r0 | r1) begin
        chk("ready_exclusive", 64'(r0 & r1), 64'(0));
        chk("ready_only_idle", 64'(v0 | v1), 64'(0));
        if (first_grant) begin
          chk("first_grant_cycle", 64'(cyc), 64'(rel_cyc));
          first_grant = 1'b0;
        end
        if (cont_mode) begin
          chk("rr_alternate", 64'(r1), 64'(last_gid == 0));
          if (last_cyc >= 0) chk("grant_spacing", 64'(cyc - last_cyc), 64'(3));
          last_gid = int'(r1);
          last_cyc = cyc;
          n_grants++;
        end
      end
      if (v0) begin
        chk("resp0_expected", 64'(q0.size() != 0), 64'(1));
        if (q0.size() != 0) begin
          chk("resp0_data", 64'(bus.resp0_data), 64'(q0[0].d));
          if (!seen0) begin
            chk("resp0_latency", 64'(cyc - q0[0].t), 64'(2));
            seen0 = 1'b1;
          end
          if (bus.resp0_ready) begin
            void'(q0.pop_front());
            seen0 = 1'b0;
          end
        end
      end
      if (v1) begin
        chk("resp1_expected", 64'(q1.size() != 0), 64'(1));
        if (q1.size() != 0) begin
          chk("resp1_data", 64'(bus.resp1_data), 64'(q1[0].d));
          if (!seen1) begin
            chk("resp1_latency", 64'(cyc - q1[0].t), 64'(2));
            seen1 = 1'b1;
          end
          if (bus.resp1_ready) begin
            void'(q1.pop_front());
            seen1 = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    cyc = 0; n_checks = 0; n_fail = 0; rr_mode = 0;
    cont_mode = 0; first_grant = 0; rel_cyc = 0;
    last_gid = 1; last_cyc = -1; n_grants = 0;
    rst = 1'b1;
    flush();
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #1;

    // Single load on requester 0
    apply_reset(1'b0);
    issue(0, 3, 5, 1'b0);
    drain();
    chk("single_data0", 64'(bus.resp0_data), 64'(15));
    chk("single_data1", 64'(bus.resp1_data), 64'(0));

    // Load then accumulate on requester 1
    apply_reset(1'b0);
    issue(1, 3, 5, 1'b0);
    issue(1, 10, 12, 1'b1);
    drain();
    chk("accum_data1", 64'(bus.resp1_data), 64'(135));
    chk("accum_data0", 64'(bus.resp0_data), 64'(0));

    // Negative operand, ones-complement result
    issue(0, -3, 5, 1'b0);
    drain();
    chk("neg_data0", 64'(bus.resp0_data), 64'(24'hFFFFF5));
    chk("neg_data1_kept", 64'(bus.resp1_data), 64'(135));

    // Contention from reset: both valid continuously
    cont_mode = 1'b1; last_gid = 1; last_cyc = -1; n_grants = 0;
    fork
      apply_reset(1'b1);
      begin
        for (int i = 0; i < 4; i++) issue(0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      end
    join
    drain();
    cont_mode = 1'b0;
    chk("cont_grants", 64'(n_grants), 64'(8));

    // Backpressure on requester 0, then reset during RESP
    rr_mode = 2;
    step(2);
    issue(0, 7, 9, 1'b0);
    fork
      issue(1, 2, 2, 1'b0);
    join_none
    t = 0;
    @(negedge clk);
    while (!bus.resp0_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("bp_resp_seen", 64'(bus.resp0_valid), 64'(1));
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", 64'(bus.resp0_valid), 64'(1));
      chk("bp_no_ready", 64'(bus.req1_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    flush();
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rr_mode = 0;
    wait fork;
    drain();
    chk("abort_acc0", 64'(bus.resp0_data), 64'(0));
    chk("after_abort_acc1", 64'(bus.resp1_data), 64'(acc_m[1]));

    // Randomized traffic with random response backpressure
    rr_mode = 1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          step($urandom_range(0, 3));
          issue(0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          step($urandom_range(0, 3));
          issue(1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
      end
    join
    rr_mode = 0;
    drain();
    chk("rand_acc0", 64'(bus.resp0_data), 64'(acc_m[0]));
    chk("rand_acc1", 64'(bus.resp1_data), 64'(acc_m[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
